util_fifo_stepup_wr_arb: RTL

- Round-robin write-port arbiter placed in front of a step-up (narrow-to-wide packing) FIFO; shares one FIFO write port among NUM_REQ producers.
- Grants are atomic per packing group: once granted, a producer owns the port for exactly OUTPUT_SCALE accepted beats, so every wide output word holds data from a single source.
- A stalled group is completed with PAD_VALUE beats after a timeout, which keeps FIFO word alignment intact.

---
 rtl/util_fifo_stepup_wr_arb.sv | 117 +++++++++++
 1 files changed

// File: rtl/util_fifo_stepup_wr_arb.sv
// util_fifo_stepup_wr_arb: round-robin write arbiter granting whole packing groups to a step-up FIFO
module util_fifo_stepup_wr_arb #(
    parameter int                     NUM_REQ      = 4,
    parameter int                     INPUT_WIDTH  = 32,
    parameter int                     OUTPUT_SCALE = 2,
    parameter int                     TIMEOUT      = 16,
    parameter logic [INPUT_WIDTH-1:0] PAD_VALUE    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [INPUT_WIDTH-1:0]         fifo_din,
    output logic                           fifo_wren,
    input  logic                           fifo_full,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic [15:0]                    pad_count
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = OUTPUT_SCALE > 1 ? $clog2(OUTPUT_SCALE) : 1;
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(OUTPUT_SCALE - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, GRANT, PAD} state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [IW-1:0]      own, own_n, last, last_n, base, win, k;
    logic [BW-1:0]      beat_cnt, beat_n;
    logic [TW-1:0]      tmo_cnt, tmo_n;
    logic [15:0]        pad_n;
    logic               found, timeout_hit, acc, pad_wr, done;

    assign timeout_hit = (TIMEOUT > 0) && state == GRANT && tmo_cnt == TMO_MAX;
    assign acc         = rst_n && state == GRANT && req_valid[own] && !fifo_full && !timeout_hit;
    assign pad_wr      = rst_n && state == PAD && !fifo_full;
    assign done        = (acc || pad_wr) && beat_cnt == LAST_BEAT;
    assign fifo_wren   = acc || pad_wr;
    assign fifo_din    = state == PAD ? PAD_VALUE : req_data[own*INPUT_WIDTH +: INPUT_WIDTH];
    assign req_ready   = (rst_n && state == GRANT && !fifo_full && !timeout_hit) ? grant : '0;
    assign busy        = rst_n && state != IDLE;
    // the finishing owner searches from itself onward, so it ends up with lowest priority
    assign base        = state == IDLE ? last : own;

    always_comb begin
        found = 1'b0;
        win   = '0;
        k     = base;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (k == IW'(NUM_REQ - 1)) ? '0 : k + 1'b1;
            if (!found && req_valid[k]) begin
                found = 1'b1;
                win   = k;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        own_n   = own;
        last_n  = last;
        beat_n  = beat_cnt;
        tmo_n   = tmo_cnt;
        pad_n   = pad_count + {15'd0, pad_wr && pad_count != 16'hFFFF};
        if (state == IDLE) begin
            if (found) begin
                state_n = GRANT;
                grant_n = ONE << win;
                own_n   = win;
                beat_n  = '0;
                tmo_n   = '0;
            end
        end else if (done) begin
            last_n  = own;
            beat_n  = '0;
            tmo_n   = '0;
            state_n = found ? GRANT : IDLE;
            grant_n = found ? ONE << win : '0;
            own_n   = found ? win : own;
        end else if (timeout_hit) begin
            tmo_n   = '0;
            state_n = beat_cnt == '0 ? IDLE : PAD;
            grant_n = beat_cnt == '0 ? '0 : grant;
            last_n  = beat_cnt == '0 ? own : last;
        end else if (acc || pad_wr) begin
            beat_n = beat_cnt + 1'b1;
            tmo_n  = '0;
        end else if (TIMEOUT > 0 && state == GRANT && !req_valid[own]) begin
            tmo_n = tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            own       <= '0;
            last      <= IW'(NUM_REQ - 1);
            beat_cnt  <= '0;
            tmo_cnt   <= '0;
            pad_count <= '0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            own       <= own_n;
            last      <= last_n;
            beat_cnt  <= beat_n;
            tmo_cnt   <= tmo_n;
            pad_count <= pad_n;
        end
    end
endmodule
